// File: rtl/hpdl_display_ctrl.sv
// hpdl_display_ctrl
//   Character-buffer display controller for NUM_DEVICES chained HPDL-1414
//   modules (4 characters each). Accepts a byte stream, interprets control
//   codes (BKSP, CR, FF), folds lowercase to uppercase, optionally scrolls,
//   and continuously refreshes the displays over a shared bus with a
//   blinking cursor.
//
// Ports
//   CLK_i       system clock
//   RST_i       synchronous active-high reset
//   RX_VALID_i  byte strobe (transfer when RX_VALID_i && RX_READY_o)
//   RX_DATA_i   received byte
//   RX_READY_o  high when a byte can be accepted (IDLE only)
//   HPDL_D      character code to the displays
//   HPDL_A      digit address within a device (inverted position)
//   HPDL_WR_N   active-low per-device write strobes
//   CURSOR_o    cursor position 0..DEPTH (DEPTH = past the end)
module hpdl_display_ctrl #(
    parameter int NUM_DEVICES  = 4,
    parameter int CLK_DIV_LOG2 = 10,
    parameter int BLINK_LOG2   = 22,
    parameter int SCROLL_MODE  = 0
) (
    input  logic                                  CLK_i,
    input  logic                                  RST_i,
    input  logic                                  RX_VALID_i,
    input  logic [7:0]                            RX_DATA_i,
    output logic                                  RX_READY_o,
    output logic [6:0]                            HPDL_D,
    output logic [1:0]                            HPDL_A,
    output logic [NUM_DEVICES-1:0]                HPDL_WR_N,
    output logic [$clog2(4*NUM_DEVICES+1)-1:0]    CURSOR_o
);
    localparam int DEPTH = 4 * NUM_DEVICES;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(DEPTH);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                state;
    logic [6:0]            buffer [DEPTH];
    logic [SW-1:0]         clr_idx;
    logic [SW-1:0]         slot;
    logic [BLINK_LOG2-1:0] counter;

    logic [BLINK_LOG2-1:0] cnt_n;
    logic                  div_wrap;
    logic [SW-1:0]         slot_n;
    logic [NUM_DEVICES-1:0] wr_n_n;
    logic [6:0]            disp_d;
    logic                  accept;
    logic                  is_print;
    logic [6:0]            code;
    logic [CW-1:0]         cur_m1;

    // Refresh timing is evaluated for the counter value after this edge, so
    // the registered A/D/WR_N outputs line up with the slot they belong to.
    always_comb begin
        cnt_n    = counter + 1'b1;
        div_wrap = (counter[CLK_DIV_LOG2-1:0] == '1);
        slot_n   = slot;
        if (div_wrap) begin
            slot_n = (slot == SW'(DEPTH - 1)) ? '0 : slot + 1'b1;
        end

        wr_n_n = '1;
        for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
            if (cnt_n[CLK_DIV_LOG2-1] && (d == 32'(slot_n >> 2))) begin
                wr_n_n[d] = 1'b0;
            end
        end

        disp_d = buffer[slot_n];
        if ((CW'(slot_n) == CURSOR_o) && cnt_n[BLINK_LOG2-1]) begin
            disp_d = 7'h5F;
        end

        accept   = RX_VALID_i && RX_READY_o;
        code     = RX_DATA_i[6:0];
        is_print = 1'b0;
        if (RX_DATA_i >= 8'h20 && RX_DATA_i <= 8'h5F) begin
            is_print = 1'b1;
        end else if (RX_DATA_i >= 8'h61 && RX_DATA_i <= 8'h7A) begin
            is_print = 1'b1;
            code     = RX_DATA_i[6:0] - 7'h20;
        end

        cur_m1 = CURSOR_o - 1'b1;
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state      <= ST_CLEAR;
            clr_idx    <= '0;
            CURSOR_o   <= '0;
            RX_READY_o <= 1'b0;
            counter    <= '0;
            slot       <= '0;
            HPDL_D     <= 7'h20;
            HPDL_A     <= 2'b11;
            HPDL_WR_N  <= '1;
        end else begin
            counter   <= cnt_n;
            slot      <= slot_n;
            HPDL_WR_N <= wr_n_n;
            if (div_wrap) begin
                HPDL_A <= ~slot_n[1:0];
                HPDL_D <= disp_d;
            end

            case (state)
                ST_CLEAR: begin
                    buffer[clr_idx] <= 7'h20;
                    if (clr_idx == SW'(DEPTH - 1)) begin
                        clr_idx    <= '0;
                        CURSOR_o   <= '0;
                        RX_READY_o <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            if (CURSOR_o != CW'(DEPTH)) begin
                                buffer[CURSOR_o[SW-1:0]] <= code;
                                CURSOR_o <= CURSOR_o + 1'b1;
                            end else if (SCROLL_MODE != 0) begin
                                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                                    buffer[i] <= buffer[i + 1];
                                end
                                buffer[DEPTH-1] <= code;
                            end
                        end else begin
                            case (RX_DATA_i)
                                8'h08: begin
                                    if (CURSOR_o != '0) begin
                                        CURSOR_o <= cur_m1;
                                        buffer[cur_m1[SW-1:0]] <= 7'h20;
                                    end
                                end
                                8'h0D: CURSOR_o <= '0;
                                8'h0C: begin
                                    state      <= ST_CLEAR;
                                    clr_idx    <= '0;
                                    RX_READY_o <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_hpdl_display_ctrl.sv
// Bench for hpdl_display_ctrl: two instances (drop / scroll) share the same
// byte stream and are compared every cycle against a behavioural model.
module tb_hpdl_display_ctrl;
    localparam int ND    = 4;
    localparam int DEP   = 16;
    localparam int KDIV  = 2;
    localparam int BLINK = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;

    logic       rdy0, rdy1;
    logic [6:0] hd0, hd1;
    logic [1:0] ha0, ha1;
    logic [3:0] hw0, hw1;
    logic [4:0] cur0, cur1;

    int checks = 0;
    int errors = 0;

    // model state
    int mbuf [2][DEP];
    int mcur [2];
    int ed   [2];
    int ea;
    int mready;
    int clr_left;
    int t;

    hpdl_display_ctrl #(.NUM_DEVICES(ND), .CLK_DIV_LOG2(KDIV), .BLINK_LOG2(BLINK), .SCROLL_MODE(0)) u_dut0 (
        .CLK_i(clk), .RST_i(rst), .RX_VALID_i(valid), .RX_DATA_i(data), .RX_READY_o(rdy0),
        .HPDL_D(hd0), .HPDL_A(ha0), .HPDL_WR_N(hw0), .CURSOR_o(cur0));

    hpdl_display_ctrl #(.NUM_DEVICES(ND), .CLK_DIV_LOG2(KDIV), .BLINK_LOG2(BLINK), .SCROLL_MODE(1)) u_dut1 (
        .CLK_i(clk), .RST_i(rst), .RX_VALID_i(valid), .RX_DATA_i(data), .RX_READY_o(rdy1),
        .HPDL_D(hd1), .HPDL_A(ha1), .HPDL_WR_N(hw1), .CURSOR_o(cur1));

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour, given the inputs seen there.
    task automatic model_step(input bit r, input bit v, input bit [7:0] d);
        int code, tn, s, blink;
        if (r) begin
            t = 0; mready = 0; clr_left = DEP; ea = 3;
            for (int m = 0; m < 2; m++) begin mcur[m] = 0; ed[m] = 8'h20; end
            return;
        end
        tn = t + 1;
        if (tn % (1 << KDIV) == 0) begin
            s     = (tn >> KDIV) % DEP;
            blink = (tn >> (BLINK - 1)) & 1;
            ea    = (~s) & 3;
            for (int m = 0; m < 2; m++)
                ed[m] = (s == mcur[m] && blink == 1) ? 8'h5F : mbuf[m][s];
        end
        t = tn;
        if (clr_left > 0) begin
            for (int m = 0; m < 2; m++) mbuf[m][DEP - clr_left] = 8'h20;
            clr_left--;
            if (clr_left == 0) begin
                mready = 1;
                for (int m = 0; m < 2; m++) mcur[m] = 0;
            end
        end else if (mready == 1 && v) begin
            code = -1;
            if (d >= 8'h20 && d <= 8'h5F) code = d;
            else if (d >= 8'h61 && d <= 8'h7A) code = d - 8'h20;
            for (int m = 0; m < 2; m++) begin
                if (code >= 0) begin
                    if (mcur[m] < DEP) begin
                        mbuf[m][mcur[m]] = code;
                        mcur[m]++;
                    end else if (m == 1) begin
                        for (int i = 0; i < DEP - 1; i++) mbuf[m][i] = mbuf[m][i + 1];
                        mbuf[m][DEP - 1] = code;
                    end
                end else if (d == 8'h08 && mcur[m] > 0) begin
                    mcur[m]--;
                    mbuf[m][mcur[m]] = 8'h20;
                end else if (d == 8'h0D) begin
                    mcur[m] = 0;
                end
            end
            if (d == 8'h0C) begin
                mready = 0;
                clr_left = DEP;
            end
        end
    endtask

    // Per-cycle compare process.
    initial begin
        int ew;
        forever begin
            @(posedge clk);
            model_step(rst, valid, data);
            #1;
            ew = 15;
            if ((t % (1 << KDIV)) >= (1 << (KDIV - 1)))
                ew &= ~(1 << (((t >> KDIV) % DEP) / 4));
            chk("rdy0", rdy0, mready);
            chk("rdy1", rdy1, mready);
            chk("cur0", cur0, mcur[0]);
            chk("cur1", cur1, mcur[1]);
            chk("A0", ha0, ea);
            chk("A1", ha1, ea);
            chk("D0", hd0, ed[0]);
            chk("D1", hd1, ed[1]);
            chk("WR0", hw0, ew);
            chk("WR1", hw1, ew);
        end
    end

    task automatic send(input bit [7:0] b);
        int n = 0;
        while (!rdy0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_wait", rdy0, 1);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    function automatic bit [7:0] pick();
        int r = $urandom_range(99);
        if (r < 55) return 8'($urandom_range(8'h5F, 8'h20));
        if (r < 75) return 8'($urandom_range(8'h7A, 8'h61));
        if (r < 82) return 8'h08;
        if (r < 84) return 8'h0D;
        if (r < 85) return 8'h0C;
        return 8'($urandom);
    endfunction

    initial begin
        int cnt, bad, lowc, badd, seen_us, seen_sp;
        int exp_cur[5];

        // reset release and clear length
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (!rdy0 && cnt < 100) begin @(posedge clk); #1; cnt++; end
        chk("ready_low_after_reset", cnt, 16);
        chk("cursor_after_reset", cur0, 0);

        // one frame of blanks (cursor at 0 may blink as '_')
        bad = 0;
        repeat (64) begin
            @(posedge clk); #1;
            if (!(hd0 == 7'h20 || (ha0 == 2'b11 && hd0 == 7'h5F))) bad++;
            if (!(hd1 == 7'h20 || (ha1 == 2'b11 && hd1 == 7'h5F))) bad++;
        end
        chk("blank_frame_bad", bad, 0);
        @(negedge clk);

        // "hI!"
        send(8'h68); send(8'h49); send(8'h21);
        chk("cursor_hi", cur0, 3);
        chk("model_buf0", mbuf[0][0], 8'h48);
        chk("model_buf1", mbuf[0][1], 8'h49);
        chk("model_buf2", mbuf[0][2], 8'h21);
        cnt = 0;
        while (!(ha0 == 2'b11 && hw0 == 4'b1110) && cnt < 200) begin @(posedge clk); #1; cnt++; end
        while (ha0 != 2'b10 && cnt < 200) begin @(posedge clk); #1; cnt++; end
        chk("slot1_found", (cnt < 200) ? 1 : 0, 1);
        lowc = 0; badd = 0;
        for (int i = 0; i < 4; i++) begin
            if (hw0 == 4'b1110) lowc++;
            if (hd0 != 7'h49) badd++;
            @(posedge clk); #1;
        end
        chk("slot1_wr_low_cycles", lowc, 2);
        chk("slot1_data_bad", badd, 0);
        @(negedge clk);

        // CR, "AB", 3x BKSP
        send(8'h0D);
        chk("cursor_cr", cur0, 0);
        exp_cur = '{1, 2, 1, 0, 0};
        send(8'h41); chk("cursor_A", cur0, exp_cur[0]);
        send(8'h42); chk("cursor_B", cur0, exp_cur[1]);
        send(8'h08); chk("cursor_bk1", cur0, exp_cur[2]);
        send(8'h08); chk("cursor_bk2", cur0, exp_cur[3]);
        send(8'h08); chk("cursor_bk3", cur0, exp_cur[4]);
        chk("model_bk_buf0", mbuf[0][0], 8'h20);
        chk("model_bk_buf1", mbuf[0][1], 8'h20);

        // clear, then overfill
        send(8'h0C);
        repeat (17) send(8'h41);
        send(8'h5A);
        chk("cursor_full0", cur0, 16);
        chk("cursor_full1", cur1, 16);
        chk("model_drop_last", mbuf[0][15], 8'h41);
        chk("model_scroll_first", mbuf[1][0], 8'h41);
        chk("model_scroll_14", mbuf[1][14], 8'h41);
        chk("model_scroll_last", mbuf[1][15], 8'h5A);
        repeat (70) @(negedge clk);

        // FF with valid held high carrying 'Q'
        valid = 1'b1; data = 8'h0C;
        @(negedge clk);
        data = 8'h51;
        cnt = 0;
        while (!rdy0 && cnt < 100) begin @(posedge clk); #1; cnt++; end
        chk("ff_ready_low", cnt, 16);
        @(negedge clk);
        @(negedge clk);
        valid = 1'b0;
        chk("cursor_after_Q", cur0, 1);
        chk("model_Q", mbuf[0][0], 8'h51);

        // cursor at 5 blinks in slot 5 only
        send(8'h42); send(8'h43); send(8'h44); send(8'h45);
        chk("cursor_blink", cur0, 5);
        seen_us = 0; seen_sp = 0; bad = 0;
        repeat (320) begin
            @(posedge clk); #1;
            if (hw0 == 4'b1101 && ha0 == 2'b10) begin
                if (hd0 == 7'h5F) seen_us++;
                else if (hd0 == 7'h20) seen_sp++;
            end else if (hw0 != 4'hF && hd0 == 7'h5F) bad++;
        end
        chk("blink_seen_underscore", (seen_us > 0) ? 1 : 0, 1);
        chk("blink_seen_buffer", (seen_sp > 0) ? 1 : 0, 1);
        chk("blink_other_slots", bad, 0);
        @(negedge clk);

        // reset in the middle of a write pulse
        cnt = 0;
        while (hw0 == 4'hF && cnt < 100) begin @(negedge clk); cnt++; end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_midslot_wr", hw0, 4'hF);
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        repeat (4000) begin
            rst   = ($urandom_range(499) == 0);
            valid = ($urandom_range(2) != 0);
            data  = pick();
            @(negedge clk);
        end
        rst = 1'b0; valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
